// File: rtl/ex_md_stage.sv
// Execute stage with operand forwarding, ALU, and an iterative multiply/divide
// unit owning HI/LO. Stalls HI/LO-dependent instructions while the unit iterates.
module ex_md_stage #(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int MUL_CYC = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ex_valid,
    input  logic [5:0]    i_ex_alu_ctl,
    input  logic          i_ex_alu_sign,
    input  logic          i_ex_alu_src1,
    input  logic          i_ex_alu_src2,
    input  logic [1:0]    i_ex_reg_dst,
    input  logic [3:0]    i_ex_md_op,
    input  logic [DW-1:0] i_ex_shamt,
    input  logic [DW-1:0] i_ex_imm,
    input  logic [RW-1:0] i_ex_rs,
    input  logic [RW-1:0] i_ex_rt,
    input  logic [RW-1:0] i_ex_rd,
    input  logic [DW-1:0] i_ex_rs_data,
    input  logic [DW-1:0] i_ex_rt_data,
    input  logic          i_ex_mem_write,
    input  logic          i_ex_mem_read,
    input  logic          i_ex_reg_write,
    input  logic [1:0]    i_ex_mem_to_reg,
    input  logic [DW-1:0] i_ex_pc_plus4,
    input  logic          i_mem_reg_write,
    input  logic [RW-1:0] i_mem_wr_reg,
    input  logic [DW-1:0] i_mem_wr_data,
    input  logic          i_wb_reg_write,
    input  logic [RW-1:0] i_wb_wr_reg,
    input  logic [DW-1:0] i_wb_wr_data,
    input  logic          i_mem_hold,
    output logic          o_ex_stall,
    output logic [RW-1:0] o_ex_wr_reg,
    output logic          o_md_busy,
    output logic [DW-1:0] o_em_alu_result,
    output logic [DW-1:0] o_em_store_data,
    output logic [DW-1:0] o_em_pc_plus4,
    output logic [RW-1:0] o_em_wr_reg,
    output logic          o_em_mem_write,
    output logic          o_em_mem_read,
    output logic          o_em_reg_write,
    output logic [1:0]    o_em_mem_to_reg
);
    localparam int CW = ($clog2(DW + 1) > $clog2(MUL_CYC + 1)) ? $clog2(DW + 1) : $clog2(MUL_CYC + 1);
    localparam int SW = $clog2(DW);

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_t;

    md_state_t r_state, w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_hi, r_lo, r_quo, r_rem, r_dvs, r_dvd;
    logic            r_signed, r_neg_q, r_neg_r, r_div_zero;

    logic [RW-1:0]   w_fwd_idx  [2];
    logic [DW-1:0]   w_fwd_rf   [2];
    logic [DW-1:0]   w_fwd_data [2];
    logic [DW-1:0]   w_rs_fwd, w_rt_fwd;

    assign w_fwd_idx[0] = i_ex_rs;
    assign w_fwd_idx[1] = i_ex_rt;
    assign w_fwd_rf[0]  = i_ex_rs_data;
    assign w_fwd_rf[1]  = i_ex_rt_data;

    // MEM has priority over WB; register 0 is never forwarded.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd_data[gi] =
                (i_mem_reg_write && (i_mem_wr_reg != '0) && (i_mem_wr_reg == w_fwd_idx[gi])) ? i_mem_wr_data :
                (i_wb_reg_write  && (i_wb_wr_reg  != '0) && (i_wb_wr_reg  == w_fwd_idx[gi])) ? i_wb_wr_data  :
                w_fwd_rf[gi];
        end
    endgenerate

    assign w_rs_fwd = w_fwd_data[0];
    assign w_rt_fwd = w_fwd_data[1];

    logic w_op_mul, w_op_div, w_op_md, w_op_hilo, w_signed_op;
    logic w_busy, w_load, w_advance, w_md_issue, w_mt_hi, w_mt_lo, w_md_done;

    assign w_op_mul    = (i_ex_md_op == 4'd1) || (i_ex_md_op == 4'd2);
    assign w_op_div    = (i_ex_md_op == 4'd3) || (i_ex_md_op == 4'd4);
    assign w_op_md     = w_op_mul || w_op_div;
    assign w_op_hilo   = (i_ex_md_op >= 4'd1) && (i_ex_md_op <= 4'd8);
    assign w_signed_op = (i_ex_md_op == 4'd1) || (i_ex_md_op == 4'd3);

    assign w_busy     = (r_state != MD_IDLE);
    assign o_md_busy  = w_busy;
    assign o_ex_stall = i_ex_valid && w_busy && w_op_hilo;
    assign w_load     = i_ex_valid && !o_ex_stall;
    assign w_advance  = w_load && !i_mem_hold;
    assign w_md_issue = w_advance && w_op_md;
    assign w_mt_hi    = w_advance && (i_ex_md_op == 4'd7);
    assign w_mt_lo    = w_advance && (i_ex_md_op == 4'd8);

    logic          w_sa, w_sb;
    logic [DW-1:0] w_mag_a, w_mag_b;

    assign w_sa    = w_signed_op && w_rs_fwd[DW-1];
    assign w_sb    = w_signed_op && w_rt_fwd[DW-1];
    assign w_mag_a = w_sa ? -w_rs_fwd : w_rs_fwd;
    assign w_mag_b = w_sb ? -w_rt_fwd : w_rt_fwd;

    // One restoring step: the borrow of the trial subtraction decides the quotient bit.
    logic [DW:0]     w_rem_shift, w_rem_diff;
    logic            w_rem_ge;
    logic [DW-1:0]   w_rem_step, w_quo_step;
    logic [2*DW-1:0] w_mul_a, w_mul_b, w_prod;
    logic [DW-1:0]   w_hi_res, w_lo_res;

    assign w_rem_shift = {r_rem, r_quo[DW-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_dvs};
    assign w_rem_ge    = !w_rem_diff[DW];
    assign w_rem_step  = w_rem_ge ? w_rem_diff[DW-1:0] : w_rem_shift[DW-1:0];
    assign w_quo_step  = {r_quo[DW-2:0], w_rem_ge};

    assign w_mul_a = {{DW{r_signed && r_quo[DW-1]}}, r_quo};
    assign w_mul_b = {{DW{r_signed && r_dvs[DW-1]}}, r_dvs};
    assign w_prod  = w_mul_a * w_mul_b;

    always_comb begin
        w_hi_res = w_prod[2*DW-1:DW];
        w_lo_res = w_prod[DW-1:0];
        if (r_state == MD_DIV) begin
            if (r_div_zero) begin
                w_hi_res = r_dvd;
                w_lo_res = '1;
            end else begin
                w_hi_res = r_neg_r ? -w_rem_step : w_rem_step;
                w_lo_res = r_neg_q ? -w_quo_step : w_quo_step;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_md_done    = 1'b0;
        case (r_state)
            MD_IDLE: if (w_md_issue) w_state_next = w_op_mul ? MD_MUL : MD_DIV;
            MD_MUL, MD_DIV: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = MD_IDLE;
                    w_md_done    = 1'b1;
                end
            end
            default: w_state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= MD_IDLE;
        else       r_state <= w_state_next;
    end

    // MD datapath; for MUL, r_quo/r_dvs simply hold the raw operands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0; r_hi <= '0; r_lo <= '0;
            r_quo <= '0; r_rem <= '0; r_dvs <= '0; r_dvd <= '0;
            r_signed <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_div_zero <= 1'b0;
        end else begin
            if (w_md_issue) begin
                r_cnt      <= w_op_mul ? CW'(MUL_CYC) : CW'(DW);
                r_signed   <= w_signed_op;
                r_neg_q    <= w_sa ^ w_sb;
                r_neg_r    <= w_sa;
                r_div_zero <= (w_rt_fwd == '0);
                r_dvd      <= w_rs_fwd;
                r_rem      <= '0;
                r_quo      <= w_op_mul ? w_rs_fwd : w_mag_a;
                r_dvs      <= w_op_mul ? w_rt_fwd : w_mag_b;
            end else if (w_busy) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_state == MD_DIV) begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                end
                if (w_md_done) begin
                    r_hi <= w_hi_res;
                    r_lo <= w_lo_res;
                end
            end
            if (w_mt_hi) r_hi <= w_rs_fwd;
            if (w_mt_lo) r_lo <= w_rs_fwd;
        end
    end

    logic [DW-1:0] w_op1, w_op2, w_alu, w_ex_result;
    logic [SW-1:0] w_sh;
    logic          w_lt;

    assign w_op1 = i_ex_alu_src1 ? i_ex_shamt : w_rs_fwd;
    assign w_op2 = i_ex_alu_src2 ? i_ex_imm   : w_rt_fwd;
    assign w_sh  = w_op1[SW-1:0];
    assign w_lt  = i_ex_alu_sign ? ($signed(w_op1) < $signed(w_op2)) : (w_op1 < w_op2);

    // ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sll, 8 srl, 9 sra, 10 lui.
    always_comb begin
        w_alu = '0;
        case (i_ex_alu_ctl)
            6'd0:  w_alu = w_op1 + w_op2;
            6'd1:  w_alu = w_op1 - w_op2;
            6'd2:  w_alu = w_op1 & w_op2;
            6'd3:  w_alu = w_op1 | w_op2;
            6'd4:  w_alu = w_op1 ^ w_op2;
            6'd5:  w_alu = ~(w_op1 | w_op2);
            6'd6:  w_alu = {{(DW-1){1'b0}}, w_lt};
            6'd7:  w_alu = w_op2 << w_sh;
            6'd8:  w_alu = w_op2 >> w_sh;
            6'd9:  w_alu = $signed(w_op2) >>> w_sh;
            6'd10: w_alu = w_op2 << (DW / 2);
            default: w_alu = '0;
        endcase
    end

    assign w_ex_result = (i_ex_md_op == 4'd5) ? r_hi :
                         (i_ex_md_op == 4'd6) ? r_lo : w_alu;

    always_comb begin
        case (i_ex_reg_dst)
            2'b00:   o_ex_wr_reg = i_ex_rt;
            2'b01:   o_ex_wr_reg = i_ex_rd;
            2'b10:   o_ex_wr_reg = RW'(31);
            default: o_ex_wr_reg = RW'(26);
        endcase
    end

    logic [DW-1:0] r_em_alu_result, r_em_store_data, r_em_pc_plus4;
    logic [RW-1:0] r_em_wr_reg;
    logic          r_em_mem_write, r_em_mem_read, r_em_reg_write;
    logic [1:0]    r_em_mem_to_reg;

    // Bubbles only clear the control bits; data fields load unconditionally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_em_alu_result <= '0; r_em_store_data <= '0; r_em_pc_plus4 <= '0;
            r_em_wr_reg <= '0; r_em_mem_write <= 1'b0; r_em_mem_read <= 1'b0;
            r_em_reg_write <= 1'b0; r_em_mem_to_reg <= '0;
        end else if (!i_mem_hold) begin
            r_em_alu_result <= w_ex_result;
            r_em_store_data <= w_rt_fwd;
            r_em_pc_plus4   <= i_ex_pc_plus4;
            r_em_wr_reg     <= o_ex_wr_reg;
            r_em_mem_to_reg <= i_ex_mem_to_reg;
            r_em_mem_write  <= w_load && i_ex_mem_write;
            r_em_mem_read   <= w_load && i_ex_mem_read;
            r_em_reg_write  <= w_load && i_ex_reg_write && !w_op_md;
        end
    end

    assign o_em_alu_result = r_em_alu_result;
    assign o_em_store_data = r_em_store_data;
    assign o_em_pc_plus4   = r_em_pc_plus4;
    assign o_em_wr_reg     = r_em_wr_reg;
    assign o_em_mem_write  = r_em_mem_write;
    assign o_em_mem_read   = r_em_mem_read;
    assign o_em_reg_write  = r_em_reg_write;
    assign o_em_mem_to_reg = r_em_mem_to_reg;
endmodule
